// File: rtl/byte_decode_stream.sv
// Streaming ByteDecode_d: turns a byte-serial stream into 256 D-bit coefficients per frame.
// For D=12, each coefficient is reduced mod Q and a per-frame non-canonical flag is raised.
module byte_decode_stream #(
  parameter int D         = 12,
  parameter int OUT_WIDTH = 16,
  parameter int Q         = 3329
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  output logic [OUT_WIDTH-1:0] coef_o,
  output logic                 coef_valid_o,
  input  logic                 coef_ready_i,
  output logic                 coef_last_o,
  output logic                 frame_noncanon_o
);

  localparam logic [11:0] RAW_MASK = 12'((13'd1 << D) - 13'd1);
  localparam logic [11:0] Q_L      = 12'(Q);
  localparam logic [4:0]  D_L      = 5'(D);

  function automatic logic is_noncanon(input logic [11:0] raw);
    is_noncanon = (D == 12) && (raw >= Q_L);
  endfunction

  // raw < 4096 < 2Q, so one conditional subtraction is a full reduction
  function automatic logic [11:0] reduce_q(input logic [11:0] raw);
    if (is_noncanon(raw)) begin
      reduce_q = raw - Q_L;
    end else begin
      reduce_q = raw;
    end
  endfunction

  logic [19:0]          buf_r;
  logic [4:0]           cnt_r;
  logic [7:0]           idx_r;
  logic                 sticky_r;
  logic [OUT_WIDTH-1:0] coef_r;
  logic                 coef_valid_r;
  logic                 coef_last_r;
  logic                 noncanon_r;

  logic                 accept_s;
  logic                 pop_s;
  logic [11:0]          raw_s;
  logic                 raw_nc_s;
  logic [11:0]          coef_red_s;
  logic [4:0]           pos_s;
  logic [19:0]          buf_next_s;
  logic [4:0]           cnt_next_s;

  // Ready depends only on the fill level, never on downstream ready
  assign byte_ready_o = (cnt_r <= 5'd12);

  // Bit buffer next state: shift out a coefficient first, then append the new byte
  always_comb begin
    accept_s   = byte_valid_i && byte_ready_o;
    pop_s      = (cnt_r >= D_L) && (!coef_valid_r || coef_ready_i);
    raw_s      = buf_r[11:0] & RAW_MASK;
    raw_nc_s   = is_noncanon(raw_s);
    coef_red_s = reduce_q(raw_s);
    buf_next_s = buf_r;
    pos_s      = cnt_r;
    cnt_next_s = cnt_r;
    if (pop_s) begin
      buf_next_s = buf_r >> D;
      pos_s      = cnt_r - D_L;
      cnt_next_s = cnt_r - D_L;
    end else begin
      buf_next_s = buf_r;
    end
    // Bits at and above cnt are always zero, so OR-ing in the byte is safe
    if (accept_s) begin
      buf_next_s = buf_next_s | (20'(byte_i) << pos_s);
      cnt_next_s = cnt_next_s + 5'd8;
    end else begin
      cnt_next_s = cnt_next_s;
    end
  end

  // Buffer, frame index and registered coefficient output
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_r        <= 20'd0;
      cnt_r        <= 5'd0;
      idx_r        <= 8'd0;
      sticky_r     <= 1'b0;
      coef_r       <= '0;
      coef_valid_r <= 1'b0;
      coef_last_r  <= 1'b0;
      noncanon_r   <= 1'b0;
    end else begin
      buf_r <= buf_next_s;
      cnt_r <= cnt_next_s;
      if (pop_s) begin
        coef_r       <= OUT_WIDTH'(coef_red_s);
        coef_valid_r <= 1'b1;
        idx_r        <= idx_r + 8'd1;
        if (idx_r == 8'd255) begin
          coef_last_r <= 1'b1;
          noncanon_r  <= sticky_r | raw_nc_s;
          sticky_r    <= 1'b0;
        end else begin
          coef_last_r <= 1'b0;
          noncanon_r  <= 1'b0;
          sticky_r    <= sticky_r | raw_nc_s;
        end
      end else if (coef_valid_r && coef_ready_i) begin
        coef_valid_r <= 1'b0;
        coef_last_r  <= 1'b0;
        noncanon_r   <= 1'b0;
      end else begin
        coef_valid_r <= coef_valid_r;
      end
    end
  end

  assign coef_o           = coef_r;
  assign coef_valid_o     = coef_valid_r;
  assign coef_last_o      = coef_last_r;
  assign frame_noncanon_o = noncanon_r;

endmodule

// File: tb/tb_byte_decode_stream.sv
// Randomized self-checking bench: three decoder instances (D=12, 8, 1) checked
// against a bit-stream reference model that slices the byte stream into D-bit fields.
module tb_byte_decode_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic [7:0]  bin [3];
  logic        bv  [3];
  logic        br  [3];
  logic [15:0] co  [3];
  logic        cv  [3];
  logic        cr  [3];
  logic        cl  [3];
  logic        nc  [3];

  byte_decode_stream #(.D(12), .OUT_WIDTH(16), .Q(3329)) u_d12 (
    .clk_i(clk), .rst_i(rst[0]), .byte_i(bin[0]), .byte_valid_i(bv[0]), .byte_ready_o(br[0]),
    .coef_o(co[0]), .coef_valid_o(cv[0]), .coef_ready_i(cr[0]), .coef_last_o(cl[0]),
    .frame_noncanon_o(nc[0]));
  byte_decode_stream #(.D(8), .OUT_WIDTH(16), .Q(3329)) u_d8 (
    .clk_i(clk), .rst_i(rst[1]), .byte_i(bin[1]), .byte_valid_i(bv[1]), .byte_ready_o(br[1]),
    .coef_o(co[1]), .coef_valid_o(cv[1]), .coef_ready_i(cr[1]), .coef_last_o(cl[1]),
    .frame_noncanon_o(nc[1]));
  byte_decode_stream #(.D(1), .OUT_WIDTH(16), .Q(3329)) u_d1 (
    .clk_i(clk), .rst_i(rst[2]), .byte_i(bin[2]), .byte_valid_i(bv[2]), .byte_ready_o(br[2]),
    .coef_o(co[2]), .coef_valid_o(cv[2]), .coef_ready_i(cr[2]), .coef_last_o(cl[2]),
    .frame_noncanon_o(nc[2]));

  int checks = 0;
  int errors = 0;

  logic [7:0] in_q [$];
  int exp_c [$];
  int exp_l [$];
  int exp_n [$];
  int got_c [$];
  int got_l [$];
  int got_n [$];
  int got_cyc [$];
  int mpos [3];
  int mst  [3];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lane_d(input int l);
    return (l == 0) ? 12 : ((l == 1) ? 8 : 1);
  endfunction

  // Reference: read the bytes as one LSB-first bit stream, cut it into D-bit fields
  task automatic build(input int l);
    int d;
    int nco;
    d   = lane_d(l);
    nco = (in_q.size() * 8) / d;
    exp_c.delete(); exp_l.delete(); exp_n.delete();
    for (int k = 0; k < nco; k++) begin
      int val;
      int bad;
      val = 0;
      for (int b = 0; b < d; b++) begin
        int bit_idx;
        bit_idx = k * d + b;
        if (in_q[bit_idx / 8][bit_idx % 8]) val += (1 << b);
      end
      bad = (d == 12 && val >= 3329) ? 1 : 0;
      mst[l] = mst[l] | bad;
      exp_c.push_back((d == 12) ? (val % 3329) : val);
      exp_l.push_back((mpos[l] == 255) ? 1 : 0);
      if (mpos[l] == 255) begin
        exp_n.push_back(mst[l]);
        mst[l] = 0;
      end else begin
        exp_n.push_back(0);
      end
      mpos[l] = (mpos[l] + 1) % 256;
    end
  endtask

  task automatic fill_rand(input int n);
    in_q.delete();
    for (int i = 0; i < n; i++) in_q.push_back(8'($urandom));
  endtask

  // Drive in_q into lane l and check every handshaken coefficient against the model
  task automatic run(input int l, input bit vrand, input bit rrand,
                     input int stall_at, input int stall_len, output bit saw_drop);
    int bi;
    int gi;
    int cyc;
    int n;
    int ng;
    bit prev_stall;
    int prev_coef;
    bi = 0; gi = 0; cyc = 0; prev_stall = 1'b0; prev_coef = 0; saw_drop = 1'b0;
    n  = in_q.size();
    ng = exp_c.size();
    got_c.delete(); got_l.delete(); got_n.delete(); got_cyc.delete();
    while (!(bi == n && gi == ng) && cyc < 20000) begin
      @(negedge clk);
      if (prev_stall) begin
        check("hold_valid", int'(cv[l]), 1);
        check("hold_coef", int'(co[l]), prev_coef);
      end
      bv[l]  = (bi < n) && (!vrand || $urandom_range(0, 3) != 0);
      bin[l] = (bi < n) ? in_q[bi] : 8'h00;
      if (cyc >= stall_at && cyc < stall_at + stall_len) begin
        cr[l] = 1'b0;
        if (!br[l]) saw_drop = 1'b1;
      end else begin
        cr[l] = !rrand || ($urandom_range(0, 2) != 0);
      end
      if (bv[l] && br[l]) bi++;
      if (cv[l] && cr[l]) begin
        if (gi < ng) begin
          check("coef", int'(co[l]), exp_c[gi]);
          check("last", int'(cl[l]), exp_l[gi]);
          if (exp_l[gi] == 1) check("noncanon", int'(nc[l]), exp_n[gi]);
        end else begin
          check("extra_coef", gi + 1, ng);
        end
        got_c.push_back(int'(co[l]));
        got_l.push_back(int'(cl[l]));
        got_n.push_back(int'(nc[l]));
        got_cyc.push_back(cyc);
        gi++;
      end
      prev_stall = cv[l] && !cr[l];
      prev_coef  = int'(co[l]);
      cyc++;
    end
    check("timeout_coefs", gi, ng);
    check("timeout_bytes", bi, n);
    @(posedge clk);
    #1;
    bv[l] = 1'b0;
    cr[l] = 1'b1;
  endtask

  task automatic check_reset_state(input int l);
    check("rst_valid", int'(cv[l]), 0);
    check("rst_coef", int'(co[l]), 0);
    check("rst_last", int'(cl[l]), 0);
    check("rst_noncanon", int'(nc[l]), 0);
    check("rst_byte_ready", int'(br[l]), 1);
  endtask

  task automatic do_reset(input int l);
    @(negedge clk);
    rst[l] = 1'b1;
    bv[l]  = 1'b0;
    cr[l]  = 1'b1;
    @(negedge clk);
    check_reset_state(l);
    rst[l]  = 1'b0;
    mpos[l] = 0;
    mst[l]  = 0;
  endtask

  initial begin
    bit drop;
    for (int l = 0; l < 3; l++) begin
      rst[l] = 1'b1; bv[l] = 1'b0; bin[l] = 8'h00; cr[l] = 1'b1;
      mpos[l] = 0; mst[l] = 0;
    end
    repeat (2) @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      check_reset_state(l);
      rst[l] = 1'b0;
    end

    // D=12 short sequence
    in_q.delete(); in_q.push_back(8'h01); in_q.push_back(8'h23); in_q.push_back(8'h45);
    build(0);
    run(0, 1'b0, 1'b0, -1, 0, drop);
    check("t1_c0", got_c[0], 'h301);
    check("t1_c1", got_c[1], 'h452);
    check("t1_last", got_l[1], 0);
    do_reset(0);

    // D=12 non-canonical frame followed by an all-zero frame
    in_q.delete();
    for (int i = 0; i < 3; i++) in_q.push_back(8'hFF);
    for (int i = 0; i < 381 + 384; i++) in_q.push_back(8'h00);
    build(0);
    run(0, 1'b1, 1'b1, -1, 0, drop);
    check("t2_c0", got_c[0], 766);
    check("t2_c1", got_c[1], 766);
    check("t2_c2", got_c[2], 0);
    check("t2_last1", got_l[255], 1);
    check("t2_nc1", got_n[255], 1);
    check("t2_last2", got_l[511], 1);
    check("t2_nc2", got_n[511], 0);

    // D=1 bit unpacking, two frames
    fill_rand(64);
    in_q[0] = 8'hA5;
    build(2);
    run(2, 1'b1, 1'b1, -1, 0, drop);
    check("t3_b0", got_c[0], 1); check("t3_b1", got_c[1], 0);
    check("t3_b2", got_c[2], 1); check("t3_b3", got_c[3], 0);
    check("t3_b4", got_c[4], 0); check("t3_b5", got_c[5], 1);
    check("t3_b6", got_c[6], 0); check("t3_b7", got_c[7], 1);
    check("t3_last", got_l[255], 1);
    check("t3_notlast", got_l[254], 0);

    // D=8 ramp twice, no bubble across the frame boundary
    in_q.delete();
    for (int f = 0; f < 2; f++) for (int i = 0; i < 256; i++) in_q.push_back(8'(i));
    build(1);
    run(1, 1'b0, 1'b0, -1, 0, drop);
    check("t4_c255", got_c[255], 255);
    check("t4_c256", got_c[256], 0);
    check("t4_last1", got_l[255], 1);
    check("t4_last2", got_l[511], 1);
    check("t4_no_gap", got_cyc[256] - got_cyc[255], 1);

    // D=12 downstream stall mid-frame
    fill_rand(384);
    build(0);
    run(0, 1'b0, 1'b0, 60, 10, drop);
    check("t5_ready_drop", int'(drop), 1);

    // D=12 reset mid-frame with a pending coefficient, then a fresh frame
    fill_rand(100);
    build(0);
    run(0, 1'b0, 1'b0, -1, 0, drop);
    @(negedge clk);
    bv[0] = 1'b1; bin[0] = 8'($urandom); cr[0] = 1'b0;
    @(negedge clk);
    bv[0] = 1'b0;
    @(negedge clk);
    check("t6_pre_rst_valid", int'(cv[0]), 1);
    do_reset(0);
    fill_rand(384);
    build(0);
    run(0, 1'b1, 1'b1, -1, 0, drop);
    check("t6_count", got_c.size(), 256);
    check("t6_last", got_l[255], 1);

    // Random multi-frame traffic on every lane
    for (int l = 0; l < 3; l++) begin
      fill_rand(2 * 32 * lane_d(l));
      build(l);
      run(l, 1'b1, 1'b1, -1, 0, drop);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
